// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - receive framer states and status-word bit positions
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  localparam int DATA_LSB = 0;
  localparam int PAR_BIT  = 8;
  localparam int FE_BIT   = 9;
  localparam int BE_BIT   = 10;
  localparam int OE_BIT   = 11;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RX line synchroniser, flops preset to the idle-high level
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer, one status word per frame
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int FIFO_WIDTH_R = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic                    i_baud_clk,
  input  logic                    i_rst,
  input  logic                    i_rx_en,
  input  logic                    i_data_in,
  input  logic                    i_word_ready,
  output logic                    o_word_valid,
  output logic [FIFO_WIDTH_R-1:0] o_word_out,
  output logic                    o_busy
);

  logic                    w_rx_s;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_bit_cnt;
  logic [7:0]              r_shift;
  logic                    r_par;
  logic                    r_fe;
  logic                    r_stop_hi;
  logic                    r_stop_cnt;
  logic                    r_word_valid;
  logic [FIFO_WIDTH_R-1:0] r_word_out;
  logic                    w_last_stop;
  logic                    w_fe;
  logic                    w_be;
  logic                    w_publish;
  logic [FIFO_WIDTH_R-1:0] w_word;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_baud_clk),
    .i_rst (i_rst),
    .i_d   (i_data_in),
    .o_q   (w_rx_s)
  );

  // Error flags include the stop sample being taken this cycle.
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_fe        = r_fe | ~w_rx_s;
`ifdef UART_RX_PARITY_EN
  assign w_be        = (r_shift == 8'h00) & ~r_par & ~r_stop_hi & ~w_rx_s;
`else
  assign w_be        = (r_shift == 8'h00) & ~r_stop_hi & ~w_rx_s;
`endif
  assign w_publish   = (r_state == STOP) && w_last_stop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (i_rx_en && !w_rx_s) w_state_nxt = DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
`else
      DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
`endif
      PARITY: w_state_nxt = STOP;
      STOP:   if (w_last_stop) w_state_nxt = w_be ? BREAK : IDLE;
      BREAK:  if (w_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_baud_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge i_baud_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_par      <= 1'b0;
      r_fe       <= 1'b0;
      r_stop_hi  <= 1'b0;
      r_stop_cnt <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_state_nxt == DATA) begin
          r_bit_cnt  <= 3'd0;
          r_par      <= 1'b0;
          r_fe       <= 1'b0;
          r_stop_hi  <= 1'b0;
          r_stop_cnt <= 1'b0;
        end
        DATA: begin
          r_shift[r_bit_cnt] <= w_rx_s;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
        end
        PARITY: r_par <= w_rx_s;
        STOP: begin
          r_fe       <= w_fe;
          r_stop_hi  <= r_stop_hi | w_rx_s;
          r_stop_cnt <= r_stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_word                       = '0;
    w_word[DATA_LSB +: 8]        = r_shift;
    w_word[PAR_BIT]              = r_par;
    w_word[FE_BIT]               = w_fe;
    w_word[BE_BIT]               = w_be;
    w_word[OE_BIT]               = r_word_valid & ~i_word_ready;
  end

  // A publish wins over a same-cycle handshake so the new word is never lost.
  always_ff @(posedge i_baud_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_word_valid <= 1'b0;
      r_word_out   <= '0;
    end else if (w_publish) begin
      r_word_valid <= 1'b1;
      r_word_out   <= w_word;
    end else if (r_word_valid && i_word_ready) begin
      r_word_valid <= 1'b0;
    end
  end

  assign o_word_valid = r_word_valid;
  assign o_word_out   = r_word_out;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - scoreboard bench for uart_rx_framer
`timescale 1ns/1ps
module tb_uart_rx_framer;

  localparam int SYNC  = 2;
  localparam int STOPB = 1;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = SYNC + 10 + P + STOPB - 1;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        rx_en = 1'b0;
  logic        din   = 1'b1;
  logic        ready = 1'b0;
  logic        valid;
  logic        busy;
  logic [11:0] wout;

  uart_rx_framer #(
    .FIFO_WIDTH_R (12),
    .SYNC_STAGES  (SYNC),
    .STOP_BITS    (STOPB)
  ) dut (
    .i_baud_clk   (clk),
    .i_rst        (rst),
    .i_rx_en      (rx_en),
    .i_data_in    (din),
    .i_word_ready (ready),
    .o_word_valid (valid),
    .o_word_out   (wout),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [11:0] exp_q[$];
  int n_pass = 0, n_total = 0, words_seen = 0, rise_cyc = -1, start_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [11:0] model(input logic [7:0] d, input logic p,
                                        input logic [1:0] st, input logic oe);
    logic fe, all_low, be;
    fe = 1'b0;
    all_low = 1'b1;
    for (int i = 0; i < STOPB; i++) begin
      if (st[i] == 1'b0) fe = 1'b1;
      else all_low = 1'b0;
    end
    be = (d == 8'h00) && all_low && ((P == 0) || (p == 1'b0));
    return {oe, be, fe, (P == 1) ? p : 1'b0, d};
  endfunction

  always @(negedge clk) begin
    if (rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL word_unexpected: got %0h expected none", wout);
      end else begin
        check("word", wout, exp_q.pop_front());
      end
      words_seen++;
    end
    if (valid && !prev_valid) rise_cyc = cyc;
    prev_valid = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bitd(input logic b);
    din = b;
    tick();
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] st,
                            input int drop_en);
    start_cyc = cyc;
    bitd(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_en) rx_en = 1'b0;
      bitd(d[i]);
    end
    if (P == 1) bitd(p);
    for (int i = 0; i < STOPB; i++) bitd(st[i]);
    din = 1'b1;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic p, input logic [1:0] st,
                             input logic oe);
    exp_q.push_back(model(d, p, st, oe));
  endtask

  initial begin
    int n0;
    logic [7:0] rd;
    logic rp;
    logic [1:0] rs;
    int gap;

    repeat (3) tick();
    check("rst_valid", valid, 0);
    check("rst_word", wout, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    rx_en = 1'b1;
    ready = 1'b1;
    idle(3);

    rise_cyc = -1;
    expect_word(8'hA5, 1'b0, 2'b11, 1'b0);
    send_frame(8'hA5, 1'b0, 2'b11, -1);
    n0 = start_cyc;
    idle(6);
    check("a5_latency", rise_cyc - n0, LAT);
    check("a5_single_pulse", valid, 0);

    expect_word(8'h3C, 1'b0, 2'b00, 1'b0);
    send_frame(8'h3C, 1'b0, 2'b00, -1);
    idle(6);
    check("fe_back_to_idle", busy, 0);

    n0 = words_seen;
    expect_word(8'h00, 1'b0, 2'b00, 1'b0);
    din = 1'b0;
    repeat (20) tick();
    check("break_one_word", words_seen, n0 + 1);
    check("break_busy", busy, 1);
    idle(4);
    check("break_released", busy, 0);
    check("break_no_more", words_seen, n0 + 1);
    expect_word(8'h42, 1'b1, 2'b11, 1'b0);
    send_frame(8'h42, 1'b1, 2'b11, -1);
    idle(6);
    check("after_break_word", words_seen, n0 + 2);

    ready = 1'b0;
    send_frame(8'h11, 1'b0, 2'b11, -1);
    idle(2);
    expect_word(8'h22, 1'b0, 2'b11, 1'b1);
    send_frame(8'h22, 1'b0, 2'b11, -1);
    idle(6);
    check("oe_pending", valid, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge clk);
    check("oe_drained", valid, 0);
    tick();
    ready = 1'b1;

    expect_word(8'h55, 1'b1, 2'b11, 1'b0);
    expect_word(8'hAA, 1'b1, 2'b11, 1'b0);
    send_frame(8'h55, 1'b1, 2'b11, -1);
    send_frame(8'hAA, 1'b1, 2'b11, -1);
    idle(6);

    n0 = words_seen;
    expect_word(8'h96, 1'b0, 2'b11, 1'b0);
    send_frame(8'h96, 1'b0, 2'b11, 3);
    idle(6);
    check("en_drop_completes", words_seen, n0 + 1);
    send_frame(8'h33, 1'b0, 2'b11, -1);
    idle(6);
    check("en_off_no_word", words_seen, n0 + 1);
    check("en_off_idle", busy, 0);
    rx_en = 1'b1;

    ready = 1'b0;
    send_frame(8'h5A, 1'b0, 2'b11, -1);
    idle(6);
    check("pre_rst_pending", valid, 1);
    bitd(1'b0);
    for (int i = 0; i < 4; i++) bitd(rd_bit(8'h7F, i));
    din = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_word", wout, 0);
    check("midrst_busy", busy, 0);
    tick();
    tick();
    rst = 1'b1;
    ready = 1'b1;
    n0 = words_seen;
    idle(20);
    check("midrst_no_word", words_seen, n0);
    expect_word(8'h7E, 1'b0, 2'b11, 1'b0);
    send_frame(8'h7E, 1'b0, 2'b11, -1);
    idle(6);

    for (int k = 0; k < 30; k++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rd = 8'h00;
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
      gap = $urandom_range(0, 3);
      if (rs[0] == 1'b0 && gap == 0) gap = 1;
      expect_word(rd, rp, rs, 1'b0);
      send_frame(rd, rp, rs, -1);
      idle(gap);
    end

    idle(10);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
